// File: rtl/ch1_sweep_pkg.sv
// Shared types and constants for the channel-1 frequency sweep unit.
package ch1_sweep_pkg;

    localparam int unsigned FREQ_W         = 11;
    localparam int unsigned FREQ_MAX       = 2047;
    localparam int unsigned TIMER_W        = 3;
    localparam int unsigned PERIOD0_RELOAD = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        APPLY   = 2'd2,
        RECHECK = 2'd3
    } state_t;

    // Period 0 behaves as 8; in a 3-bit down-counter that wraps to 0, giving 8 ticks.
    function automatic logic [TIMER_W-1:0] reload_val(input logic [2:0] period);
        return (period == 3'd0) ? TIMER_W'(PERIOD0_RELOAD) : period;
    endfunction

endpackage

// File: rtl/ch1_sweep_alu.sv
// Combinational sweep datapath: shadow +/- (shadow >> shift), one carry bit wide.
module ch1_sweep_alu
    import ch1_sweep_pkg::*;
#(
    parameter int unsigned FREQ_W = ch1_sweep_pkg::FREQ_W
) (
    input  logic [FREQ_W-1:0] shadow,
    input  logic [2:0]        shift,
    input  logic              negate,
    output logic [FREQ_W:0]   sum_c
);

    logic [FREQ_W-1:0] delta;

    assign delta = shadow >> shift;

    // delta never exceeds shadow, so the subtraction cannot underflow.
    always_comb begin
        if (negate) begin
            sum_c = {1'b0, shadow - delta};
        end else begin
            sum_c = {1'b0, shadow} + {1'b0, delta};
        end
    end

endmodule

// File: rtl/ch1_sweep.sv
// Channel-1 frequency sweep: period timer, shadow register and overflow checking.
module ch1_sweep
    import ch1_sweep_pkg::*;
#(
    parameter int unsigned FREQ_W   = ch1_sweep_pkg::FREQ_W,
    parameter int unsigned FREQ_MAX = ch1_sweep_pkg::FREQ_MAX
) (
    input  logic              dyfa_1mhz,
    input  logic              napu_reset,
    input  logic [6:0]        nff10,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              ch1_restart,
    input  logic              sweep_tick,
    output logic [FREQ_W-1:0] freq_out,
    output logic              freq_load,
    output logic              sweep_off,
    output logic              busy
);

    localparam logic [FREQ_W:0] SUM_MAX = (FREQ_W+1)'(FREQ_MAX);

    logic [2:0]         period;
    logic [2:0]         shift;
    logic               negate;

    state_t             state_q, state_d;
    logic [FREQ_W-1:0]  shadow_q, shadow_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               sweep_en_q, sweep_en_d;
    logic [FREQ_W:0]    sum_q, sum_d;
    logic               recheck_q, recheck_d;
    logic               run_q;
    logic [FREQ_W-1:0]  freq_out_d;
    logic               freq_load_d;
    logic               sweep_off_d;

    logic [FREQ_W:0]    alu_sum;
    logic [TIMER_W-1:0] timer_dec;
    logic               timer_hit;
    logic               overflow;

    // NR10 arrives inverted from the register file.
    assign {period, negate, shift} = ~nff10;

    assign timer_dec = TIMER_W'(timer_q - TIMER_W'(1));
    assign timer_hit = (timer_dec == '0);
    assign overflow  = (sum_q > SUM_MAX);

    ch1_sweep_alu #(
        .FREQ_W (FREQ_W)
    ) u_alu (
        .shadow (shadow_q),
        .shift  (shift),
        .negate (negate),
        .sum_c  (alu_sum)
    );

    // State register and all registered outputs.
    always_ff @(posedge dyfa_1mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            timer_q    <= '0;
            sweep_en_q <= 1'b0;
            sum_q      <= '0;
            recheck_q  <= 1'b0;
            run_q      <= 1'b0;
            freq_out   <= '0;
            freq_load  <= 1'b0;
            sweep_off  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            timer_q    <= timer_d;
            sweep_en_q <= sweep_en_d;
            sum_q      <= sum_d;
            recheck_q  <= recheck_d;
            run_q      <= 1'b1;
            freq_out   <= freq_out_d;
            freq_load  <= freq_load_d;
            sweep_off  <= sweep_off_d;
            busy       <= (state_d != IDLE);
        end
    end

    // Next-state and output logic; restart overrides everything, first edge after reset is inert.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        timer_d     = timer_q;
        sweep_en_d  = sweep_en_q;
        sum_d       = sum_q;
        recheck_d   = recheck_q;
        freq_out_d  = freq_out;
        freq_load_d = 1'b0;
        sweep_off_d = 1'b0;

        if (!run_q) begin
            state_d = IDLE;
        end else if (ch1_restart) begin
            shadow_d   = freq_in;
            timer_d    = reload_val(period);
            sweep_en_d = (period != 3'd0) || (shift != 3'd0);
            recheck_d  = 1'b1;
            state_d    = (shift != 3'd0) ? CALC : IDLE;
        end else begin
            if (sweep_tick) begin
                timer_d = timer_hit ? reload_val(period) : timer_dec;
            end

            case (state_q)
                IDLE: begin
                    if (sweep_tick && timer_hit && sweep_en_q && (period != 3'd0)) begin
                        recheck_d = 1'b0;
                        state_d   = CALC;
                    end
                end
                CALC: begin
                    sum_d   = alu_sum;
                    state_d = recheck_q ? RECHECK : APPLY;
                end
                APPLY: begin
                    if (overflow) begin
                        sweep_off_d = 1'b1;
                        state_d     = IDLE;
                    end else if (shift != 3'd0) begin
                        shadow_d    = sum_q[FREQ_W-1:0];
                        freq_out_d  = sum_q[FREQ_W-1:0];
                        freq_load_d = 1'b1;
                        recheck_d   = 1'b1;
                        state_d     = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RECHECK: begin
                    sweep_off_d = overflow;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ch1_sweep.sv
// Directed self-checking bench for the channel-1 sweep unit.
module tb_ch1_sweep;

    logic        clk = 1'b0;
    logic        napu_reset = 1'b1;
    logic [6:0]  nff10 = 7'h7F;
    logic [10:0] freq_in = '0;
    logic        ch1_restart = 1'b0;
    logic        sweep_tick = 1'b0;
    logic [10:0] freq_out;
    logic        freq_load;
    logic        sweep_off;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_load = 0;
    int cnt_off = 0;

    ch1_sweep dut (
        .dyfa_1mhz   (clk),
        .napu_reset  (napu_reset),
        .nff10       (nff10),
        .freq_in     (freq_in),
        .ch1_restart (ch1_restart),
        .sweep_tick  (sweep_tick),
        .freq_out    (freq_out),
        .freq_load   (freq_load),
        .sweep_off   (sweep_off),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (freq_load) cnt_load++;
        if (sweep_off) cnt_off++;
    end

    function automatic logic [6:0] enc(input logic [2:0] p, input logic n, input logic [2:0] s);
        return ~{p, n, s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        ch1_restart = 1'b1;
        step();
        ch1_restart = 1'b0;
    endtask

    task automatic pulse_tick();
        sweep_tick = 1'b1;
        step();
        sweep_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 10) begin
            step();
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_idle: busy=%b required 0 within 10 cycles", busy);
        end
    endtask

    task automatic test_reset();
        #1 napu_reset = 1'b0;
        #1;
        n_cmp++; if (freq_out !== 11'h000) begin n_bad++; $display("FAIL reset_freq_out: got %0h want 0", freq_out); end
        n_cmp++; if (freq_load !== 1'b0) begin n_bad++; $display("FAIL reset_freq_load: got %b want 0", freq_load); end
        n_cmp++; if (sweep_off !== 1'b0) begin n_bad++; $display("FAIL reset_sweep_off: got %b want 0", sweep_off); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        // Pending restart and tick on the first edge out of reset must be ignored.
        nff10 = enc(3'd1, 1'b0, 3'd1);
        freq_in = 11'h400;
        ch1_restart = 1'b1;
        sweep_tick = 1'b1;
        napu_reset = 1'b1;
        step();
        ch1_restart = 1'b0;
        sweep_tick = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy2: got %b want 0", busy); end
    endtask

    task automatic test_add_overflow();
        nff10 = enc(3'd1, 1'b0, 3'd1);
        freq_in = 11'h400;
        pulse_restart();
        wait_idle();
        cnt_load = 0;
        cnt_off = 0;
        pulse_tick();
        step();
        step();
        n_cmp++; if (freq_load !== 1'b1) begin n_bad++; $display("FAIL add_load: got %b want 1", freq_load); end
        n_cmp++; if (freq_out !== 11'h600) begin n_bad++; $display("FAIL add_freq_out: got %0h want 600", freq_out); end
        step();
        step();
        n_cmp++; if (sweep_off !== 1'b1) begin n_bad++; $display("FAIL add_recheck_off: got %b want 1", sweep_off); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL add_idle: busy got %b want 0", busy); end
        n_cmp++; if (cnt_load !== 1) begin n_bad++; $display("FAIL add_load_count: got %0d want 1", cnt_load); end
        n_cmp++; if (cnt_off !== 1) begin n_bad++; $display("FAIL add_off_count: got %0d want 1", cnt_off); end
    endtask

    task automatic test_negate();
        nff10 = enc(3'd1, 1'b1, 3'd2);
        freq_in = 11'h400;
        pulse_restart();
        wait_idle();
        cnt_load = 0;
        cnt_off = 0;
        pulse_tick();
        step();
        step();
        n_cmp++; if (freq_load !== 1'b1) begin n_bad++; $display("FAIL neg_load: got %b want 1", freq_load); end
        n_cmp++; if (freq_out !== 11'h300) begin n_bad++; $display("FAIL neg_freq_out: got %0h want 300", freq_out); end
        repeat (5) step();
        n_cmp++; if (cnt_off !== 0) begin n_bad++; $display("FAIL neg_no_off: got %0d want 0", cnt_off); end
        n_cmp++; if (cnt_load !== 1) begin n_bad++; $display("FAIL neg_load_count: got %0d want 1", cnt_load); end
    endtask

    task automatic test_trigger_overflow();
        nff10 = enc(3'd1, 1'b0, 3'd1);
        freq_in = 11'h7FF;
        cnt_load = 0;
        cnt_off = 0;
        pulse_restart();
        n_cmp++; if (sweep_off !== 1'b0) begin n_bad++; $display("FAIL trig_off_t1: got %b want 0", sweep_off); end
        step();
        n_cmp++; if (sweep_off !== 1'b0) begin n_bad++; $display("FAIL trig_off_t2: got %b want 0", sweep_off); end
        step();
        n_cmp++; if (sweep_off !== 1'b1) begin n_bad++; $display("FAIL trig_off_t3: got %b want 1", sweep_off); end
        repeat (3) step();
        n_cmp++; if (cnt_load !== 0) begin n_bad++; $display("FAIL trig_no_load: got %0d want 0", cnt_load); end
        n_cmp++; if (cnt_off !== 1) begin n_bad++; $display("FAIL trig_off_count: got %0d want 1", cnt_off); end
    endtask

    task automatic test_disabled();
        logic busy_seen = 1'b0;
        nff10 = enc(3'd0, 1'b0, 3'd0);
        freq_in = 11'h123;
        pulse_restart();
        cnt_load = 0;
        cnt_off = 0;
        for (int i = 0; i < 20; i++) begin
            pulse_tick();
            if (busy) busy_seen = 1'b1;
            step();
            if (busy) busy_seen = 1'b1;
        end
        n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL dis_busy: got %b want 0", busy_seen); end
        n_cmp++; if (cnt_load !== 0) begin n_bad++; $display("FAIL dis_load: got %0d want 0", cnt_load); end
        n_cmp++; if (cnt_off !== 0) begin n_bad++; $display("FAIL dis_off: got %0d want 0", cnt_off); end
    endtask

    task automatic test_abort();
        nff10 = enc(3'd1, 1'b0, 3'd1);
        freq_in = 11'h100;
        pulse_restart();
        wait_idle();
        cnt_load = 0;
        cnt_off = 0;
        pulse_tick();
        step();
        // State is APPLY here; restart must win over the pending write-back.
        ch1_restart = 1'b1;
        freq_in = 11'h240;
        step();
        ch1_restart = 1'b0;
        n_cmp++; if (freq_load !== 1'b0) begin n_bad++; $display("FAIL abort_load: got %b want 0", freq_load); end
        wait_idle();
        n_cmp++; if (cnt_load !== 0) begin n_bad++; $display("FAIL abort_load_count: got %0d want 0", cnt_load); end
        pulse_tick();
        step();
        step();
        n_cmp++; if (freq_load !== 1'b1) begin n_bad++; $display("FAIL abort_next_load: got %b want 1", freq_load); end
        n_cmp++; if (freq_out !== 11'h360) begin n_bad++; $display("FAIL abort_shadow: got %0h want 360", freq_out); end
        wait_idle();
    endtask

    task automatic test_busy_tick();
        nff10 = enc(3'd1, 1'b0, 3'd1);
        freq_in = 11'h080;
        pulse_restart();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bt_busy: got %b want 1", busy); end
        pulse_tick();
        wait_idle();
        cnt_load = 0;
        cnt_off = 0;
        repeat (3) step();
        n_cmp++; if (cnt_load !== 0) begin n_bad++; $display("FAIL bt_no_seq: got %0d want 0", cnt_load); end
        pulse_tick();
        step();
        step();
        n_cmp++; if (freq_out !== 11'h0C0) begin n_bad++; $display("FAIL bt_freq_out: got %0h want c0", freq_out); end
        wait_idle();
    endtask

    task automatic test_async_reset();
        nff10 = enc(3'd1, 1'b0, 3'd1);
        freq_in = 11'h200;
        pulse_restart();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ar_calc_busy: got %b want 1", busy); end
        napu_reset = 1'b0;
        #1;
        n_cmp++; if (freq_out !== 11'h000) begin n_bad++; $display("FAIL ar_freq_out: got %0h want 0", freq_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy: got %b want 0", busy); end
        n_cmp++; if (freq_load !== 1'b0) begin n_bad++; $display("FAIL ar_load: got %b want 0", freq_load); end
        n_cmp++; if (sweep_off !== 1'b0) begin n_bad++; $display("FAIL ar_off: got %b want 0", sweep_off); end
        step();
        step();
        cnt_load = 0;
        cnt_off = 0;
        napu_reset = 1'b1;
        repeat (6) step();
        n_cmp++; if (cnt_load !== 0) begin n_bad++; $display("FAIL ar_post_load: got %0d want 0", cnt_load); end
        n_cmp++; if (cnt_off !== 0) begin n_bad++; $display("FAIL ar_post_off: got %0d want 0", cnt_off); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ar_post_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_negate();
        test_trigger_overflow();
        test_disabled();
        test_abort();
        test_busy_tick();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ch1_sweep.md
CH1_SWEEP -- requirements
Module: ch1_sweep

Interface
REQ-001 The parameter FREQ_W SHALL default to 11 and set the width of the frequency word.
REQ-002 The parameter FREQ_MAX SHALL default to 2047 and set the highest frequency value that does not overflow.
REQ-003 The port dyfa_1mhz SHALL be a 1-bit input and the only clock. All state SHALL change on its rising edge.
REQ-004 The port napu_reset SHALL be a 1-bit input: the APU reset, asynchronous and active-low.
REQ-005 The port nff10 SHALL be a 7-bit input carrying the inverted NR10 register. Bits [6:4] are the sweep period, bit [3] is the negate flag and bits [2:0] are the shift amount.
REQ-006 The port freq_in SHALL be a FREQ_W-bit input carrying the NR13/NR14 frequency value.
REQ-007 The port ch1_restart SHALL be a 1-bit input: a one-cycle trigger pulse.
REQ-008 The port sweep_tick SHALL be a 1-bit input: a one-cycle 128 Hz sweep enable.
REQ-009 The port freq_out SHALL be a FREQ_W-bit output carrying the swept frequency to be written back.
REQ-010 The port freq_load SHALL be a 1-bit output: a one-cycle pulse that loads freq_out into the frequency register and counter.
REQ-011 The port sweep_off SHALL be a 1-bit output: a one-cycle pulse that disables channel 1 on overflow.
REQ-012 The port busy SHALL be a 1-bit output that is high whenever the state is not IDLE.

Function
REQ-013 The block SHALL invert nff10 internally to obtain the period, negate and shift fields.
REQ-014 The block SHALL hold these registers:
- shadow: FREQ_W bits.
- timer: 3 bits.
- sweep_en: 1 bit.
- sum: FREQ_W+1 bits.
- state: one of IDLE, CALC, APPLY, RECHECK.
REQ-015 The sum computation SHALL be as follows:
- With negate=0, sum = shadow + (shadow >> shift).
- With negate=1, sum = shadow - (shadow >> shift).
- The result SHALL be zero-extended to FREQ_W+1 bits.
- Subtraction never goes below zero.
REQ-016 Overflow SHALL be defined as sum > FREQ_MAX, which is equivalent to sum[FREQ_W] being set.
REQ-017 On ch1_restart at cycle T, the block SHALL do all of the following at edge T+1:
- shadow <= freq_in.
- timer <= period, with period 0 loading 8.
- sweep_en <= (period != 0) || (shift != 0).
- state <= CALC if shift != 0, otherwise IDLE.
REQ-018 When sweep_tick occurs in IDLE with no restart, the block SHALL:
- decrement timer;
- on reaching 0, reload timer as in REQ-017;
- then go to CALC only if sweep_en=1 and period != 0.
REQ-019 In CALC, sum SHALL be registered. From CALC, the next state SHALL be APPLY after a tick-initiated entry and RECHECK after a restart-initiated entry.
REQ-020 In APPLY, the block SHALL act on sum as follows:
- If overflow: pulse sweep_off and go to IDLE.
- Otherwise, if shift != 0: shadow <= sum, freq_out <= sum, pulse freq_load, and go to CALC, which then continues to RECHECK.
- Otherwise: go to IDLE.
REQ-021 In RECHECK, the block SHALL pulse sweep_off if overflow, never update shadow, and always go to IDLE.
REQ-022 ch1_restart SHALL take priority in any state. It aborts any sequence in progress, and a coincident sweep_tick SHALL be dropped.
REQ-023 A sweep_tick arriving while busy=1 SHALL still update timer, and SHALL NOT start a new sequence.
REQ-024 freq_load and sweep_off SHALL never be high in the same cycle. Each SHALL be high for exactly one cycle per event.
REQ-025 nff10 SHALL be sampled live; a change mid-sequence takes effect from the next cycle.

Reset
REQ-026 When napu_reset=0, the block SHALL immediately set:
- state to IDLE;
- shadow, timer, sum and freq_out to 0;
- sweep_en, freq_load, sweep_off and busy to 0.
REQ-027 The block SHALL leave reset on the first rising dyfa_1mhz edge with napu_reset=1 and SHALL ignore any pending tick or restart.

Structure
REQ-028 The package ch1_sweep_pkg SHALL hold:
- the state enum (IDLE, CALC, APPLY, RECHECK);
- FREQ_W;
- FREQ_MAX;
- the period-0 reload constant (8).
REQ-029 The shift/add/subtract datapath SHALL be one sub-module, ch1_sweep_alu, which is purely combinational and produces a FREQ_W+1-bit result.

Verification
REQ-030 Add with overflow on recheck. Stimulus: restart with freq_in=0x400, nff10=~7'b001_0_001, then one sweep_tick. Required response: freq_load with freq_out=0x600, followed by one sweep_off pulse from RECHECK (0x900 > 2047).
REQ-031 Negate. Stimulus: freq_in=0x400, period=1, negate=1, shift=2, then one tick. Required response: freq_out=0x300 and no sweep_off.
REQ-032 Overflow at trigger. Stimulus: restart with freq_in=0x7FF, shift=1, negate=0. Required response: sweep_off at T+3 and no freq_load.
REQ-033 Sweep disabled. Stimulus: period=0, shift=0, then 20 ticks. Required response: no freq_load, no sweep_off, and busy stays 0.
REQ-034 Abort by restart. Stimulus: ch1_restart asserted in the APPLY cycle. Required response: no freq_load, and shadow equals the new freq_in.
REQ-035 Asynchronous reset. Stimulus: napu_reset pulled low mid-CALC. Required response: all outputs are 0 immediately, and there is no pulse after release.
